// File: rtl/usr_seq_pkg.sv
// Shared opcodes, shift-register mode encodings and FSM state type for the
// universal shift register command sequencer.
package usr_seq_pkg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SHR  = 3'b010;
    localparam logic [2:0] OP_SHL  = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    function automatic logic op_is_shift(input logic [2:0] op);
        return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ROR) || (op == OP_ROL);
    endfunction

    function automatic logic op_is_reserved(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/usr_shift_cnt.sv
// Loadable down-counter tracking remaining shift cycles; last flags count==1.
module usr_shift_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             last
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Next count: load has priority over decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec) begin
            cnt_d = cnt_q - ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == ONE);

endmodule

// File: rtl/usr_seq_ctrl.sv
// Command sequencer driving a 4-bit universal shift register (S1/S0, serial, parallel).
// Optional abort support is compiled in with USR_SEQ_CTRL_ABORT_EN.
module usr_seq_ctrl
    import usr_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic             cmd_fill,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [WIDTH-1:0] q,
    output logic [1:0]       sel,
    output logic             msb_in,
    output logic             lsb_in,
    output logic [WIDTH-1:0] par_out,
    output logic             busy,
    output logic             done,
`ifdef USR_SEQ_CTRL_ABORT_EN
    input  logic             abort,
    output logic             aborted,
`endif
    output logic             err
);

    state_e           state_d, state_q;
    logic [2:0]       op_d, op_q;
    logic             fill_d, fill_q;
    logic [WIDTH-1:0] data_d, data_q;
    logic             cnt_load_s;
    logic             cnt_dec_s;
    logic             cnt_last_s;
    logic             abort_s;
    logic             abort_hit_s;

`ifdef USR_SEQ_CTRL_ABORT_EN
    logic aborted_d, aborted_q;
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    usr_shift_cnt #(
        .CNT_W (CNT_W)
    ) u_shift_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load_s),
        .load_val (cmd_cnt),
        .dec      (cnt_dec_s),
        .last     (cnt_last_s)
    );

    // Next-state, command latch and datapath drive.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        fill_d      = fill_q;
        data_d      = data_q;
        cnt_load_s  = 1'b0;
        cnt_dec_s   = 1'b0;
        abort_hit_s = 1'b0;
        sel         = MODE_HOLD;
        msb_in      = 1'b0;
        lsb_in      = 1'b0;
        par_out     = '0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d       = cmd_op;
                    fill_d     = cmd_fill;
                    data_d     = cmd_data;
                    cnt_load_s = 1'b1;
                    if (cmd_op == OP_LOAD) begin
                        state_d = ST_LOAD;
                    end else if (op_is_shift(cmd_op) && (cmd_cnt != '0)) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_d = ST_DONE;
                if (abort_s) begin
                    abort_hit_s = 1'b1;
                end else begin
                    sel     = MODE_LOAD;
                    par_out = data_q;
                end
            end
            ST_SHIFT: begin
                if (abort_s) begin
                    abort_hit_s = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    cnt_dec_s = 1'b1;
                    case (op_q)
                        OP_SHR: begin
                            sel    = MODE_SHR;
                            msb_in = fill_q;
                        end
                        OP_SHL: begin
                            sel    = MODE_SHL;
                            lsb_in = fill_q;
                        end
                        // Rotates feed the wrapped bit straight from the live register.
                        OP_ROR: begin
                            sel    = MODE_SHR;
                            msb_in = q[0];
                        end
                        OP_ROL: begin
                            sel    = MODE_SHL;
                            lsb_in = q[WIDTH-1];
                        end
                        default: begin
                            sel = MODE_HOLD;
                        end
                    endcase
                    if (cnt_last_s) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef USR_SEQ_CTRL_ABORT_EN
    // Remember an abort until the completion cycle has been reported.
    always_comb begin
        if (abort_hit_s) begin
            aborted_d = 1'b1;
        end else if (state_q == ST_DONE) begin
            aborted_d = 1'b0;
        end else begin
            aborted_d = aborted_q;
        end
    end

    // Abort flag register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= aborted_d;
        end
    end

    assign aborted = (state_q == ST_DONE) && aborted_q;
`endif

    // State and latched command registers; reset abandons any command in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
            fill_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            fill_q  <= fill_d;
            data_q  <= data_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign err       = (state_q == ST_DONE) && op_is_reserved(op_q);

endmodule

// File: tb/tb_usr_seq_ctrl.sv
// Directed bench for usr_seq_ctrl with a behavioural 4-bit universal shift register.
module tb_usr_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'b000;
    logic [3:0] cmd_cnt = 4'd0;
    logic       cmd_fill = 1'b0;
    logic [3:0] cmd_data = 4'h0;
    logic [3:0] q = 4'h0;
    logic [1:0] sel;
    logic       msb_in;
    logic       lsb_in;
    logic [3:0] par_out;
    logic       busy;
    logic       done;
    logic       err;
`ifdef USR_SEQ_CTRL_ABORT_EN
    logic       abort = 1'b0;
    logic       aborted;
`endif

    int checks = 0;
    int errors = 0;

    usr_seq_ctrl #(.WIDTH(4), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_cnt   (cmd_cnt),
        .cmd_fill  (cmd_fill),
        .cmd_data  (cmd_data),
        .q         (q),
        .sel       (sel),
        .msb_in    (msb_in),
        .lsb_in    (lsb_in),
        .par_out   (par_out),
        .busy      (busy),
        .done      (done),
`ifdef USR_SEQ_CTRL_ABORT_EN
        .abort     (abort),
        .aborted   (aborted),
`endif
        .err       (err)
    );

    always #5 clk = ~clk;

    // Shift register datapath; has no reset of its own here.
    always @(posedge clk) begin
        case (sel)
            2'b01:   q <= {msb_in, q[3:1]};
            2'b10:   q <= {q[2:0], lsb_in};
            2'b11:   q <= par_out;
            default: q <= q;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [3:0] cnt,
                         input logic fill, input logic [3:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_cnt   = cnt;
        cmd_fill  = fill;
        cmd_data  = data;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        // Reset
        rst = 1'b0;
        tick();
        tick();
        chk("rst_ready", {7'd0, cmd_ready}, 8'd1);
        chk("rst_busy",  {7'd0, busy},      8'd0);
        chk("rst_done",  {7'd0, done},      8'd0);
        chk("rst_sel",   {6'd0, sel},       8'd0);
        chk("rst_err",   {7'd0, err},       8'd0);
        rst = 1'b1;
        tick();

        // LOAD 4'hA
        issue(3'b001, 4'd0, 1'b0, 4'hA);
        chk("ld_c1_sel",   {6'd0, sel},       8'h03);
        chk("ld_c1_par",   {4'd0, par_out},   8'h0A);
        chk("ld_c1_ready", {7'd0, cmd_ready}, 8'd0);
        chk("ld_c1_busy",  {7'd0, busy},      8'd1);
        chk("ld_c1_done",  {7'd0, done},      8'd0);
        tick();
        chk("ld_c2_q",    {4'd0, q},    8'h0A);
        chk("ld_c2_done", {7'd0, done}, 8'd1);
        chk("ld_c2_sel",  {6'd0, sel},  8'd0);
        tick();
        chk("ld_c3_ready", {7'd0, cmd_ready}, 8'd1);
        chk("ld_c3_done",  {7'd0, done},      8'd0);

        // SHR cnt=2 fill=1 on 1010
        issue(3'b010, 4'd2, 1'b1, 4'h0);
        chk("shr_c1_sel", {6'd0, sel},    8'h01);
        chk("shr_c1_msb", {7'd0, msb_in}, 8'd1);
        tick();
        chk("shr_c2_q",   {4'd0, q},   8'h0D);
        chk("shr_c2_sel", {6'd0, sel}, 8'h01);
        tick();
        chk("shr_c3_q",    {4'd0, q},    8'h0E);
        chk("shr_c3_done", {7'd0, done}, 8'd1);
        chk("shr_c3_sel",  {6'd0, sel},  8'd0);
        tick();

        // ROL cnt=1 on 1001
        issue(3'b001, 4'd0, 1'b0, 4'h9);
        tick();
        tick();
        issue(3'b101, 4'd1, 1'b0, 4'h0);
        chk("rol_c1_sel", {6'd0, sel},    8'h02);
        chk("rol_c1_lsb", {7'd0, lsb_in}, 8'd1);
        tick();
        chk("rol_c2_q",    {4'd0, q},    8'h03);
        chk("rol_c2_done", {7'd0, done}, 8'd1);
        tick();

        // ROR cnt=4 on 1001; a competing LOAD stays asserted and must be ignored
        issue(3'b001, 4'd0, 1'b0, 4'h9);
        tick();
        tick();
        issue(3'b100, 4'd4, 1'b0, 4'h0);
        cmd_valid = 1'b1;
        cmd_op    = 3'b001;
        cmd_data  = 4'hF;
        chk("ror_c1_sel", {6'd0, sel}, 8'h01);
        chk("ror_c1_msb", {7'd0, msb_in}, 8'd1);
        tick();
        chk("ror_c2_q", {4'd0, q}, 8'h0C);
        tick();
        tick();
        chk("ror_c4_sel", {6'd0, sel}, 8'h01);
        cmd_valid = 1'b0;
        tick();
        chk("ror_c5_q",    {4'd0, q},    8'h09);
        chk("ror_c5_done", {7'd0, done}, 8'd1);
        tick();

        // ROR cnt=5 wraps: same as one rotation
        issue(3'b100, 4'd5, 1'b0, 4'h0);
        tick(); tick(); tick(); tick();
        chk("ror5_c5_done", {7'd0, done}, 8'd0);
        tick();
        chk("ror5_c6_q",    {4'd0, q},    8'h0C);
        chk("ror5_c6_done", {7'd0, done}, 8'd1);
        tick();

        // SHL cnt=0: immediate done, no shift
        issue(3'b011, 4'd0, 1'b1, 4'h0);
        chk("shl0_done", {7'd0, done}, 8'd1);
        chk("shl0_err",  {7'd0, err},  8'd0);
        chk("shl0_sel",  {6'd0, sel},  8'd0);
        tick();
        chk("shl0_q",     {4'd0, q},         8'h0C);
        chk("shl0_ready", {7'd0, cmd_ready}, 8'd1);

        // Reserved opcode
        issue(3'b111, 4'd3, 1'b0, 4'h0);
        chk("rsv_done", {7'd0, done}, 8'd1);
        chk("rsv_err",  {7'd0, err},  8'd1);
        chk("rsv_sel",  {6'd0, sel},  8'd0);
        tick();
        chk("rsv_err_clr", {7'd0, err}, 8'd0);

        // NOP
        issue(3'b000, 4'd0, 1'b0, 4'h0);
        chk("nop_done", {7'd0, done}, 8'd1);
        chk("nop_err",  {7'd0, err},  8'd0);
        tick();

        // Reset during cycle 2 of SHR cnt=5 on 1100
        issue(3'b010, 4'd5, 1'b0, 4'h0);
        tick();
        chk("rsh_c2_sel", {6'd0, sel}, 8'h01);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("rsh_sel",   {6'd0, sel},       8'd0);
        chk("rsh_done",  {7'd0, done},      8'd0);
        chk("rsh_ready", {7'd0, cmd_ready}, 8'd1);
        chk("rsh_busy",  {7'd0, busy},      8'd0);
        tick();
        chk("rsh_q",     {4'd0, q},    8'h03);
        chk("rsh_done2", {7'd0, done}, 8'd0);

`ifdef USR_SEQ_CTRL_ABORT_EN
        // Abort in second SHIFT cycle of ROR cnt=4 on 1001
        issue(3'b001, 4'd0, 1'b0, 4'h9);
        tick();
        tick();
        issue(3'b100, 4'd4, 1'b0, 4'h0);
        chk("ab_c1_sel", {6'd0, sel}, 8'h01);
        tick();
        abort = 1'b1;
        #1;
        chk("ab_c2_sel", {6'd0, sel}, 8'd0);
        tick();
        abort = 1'b0;
        chk("ab_done",    {7'd0, done},    8'd1);
        chk("ab_aborted", {7'd0, aborted}, 8'd1);
        chk("ab_q",       {4'd0, q},       8'h0C);
        tick();
        chk("ab_aborted_clr", {7'd0, aborted}, 8'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/usr_seq_ctrl.md
Name: usr_seq_ctrl

Overview:
Command sequencer for the 4-bit universal shift register (mode select S1/S0, serial MSB/LSB inputs, parallel load).
- Accepts one command at a time over a valid/ready handshake: load, shift right/left with constant fill, rotate right/left, or NOP.
- Drives the register's mode and serial/parallel inputs for the required number of cycles, then pulses done.
- Sits between a host/CPU-side command source and the shift register datapath.

Parameters:
WIDTH, 4, shift register width (Q/I width).
CNT_W, 4, width of shift-count field; max shifts per command = 2^CNT_W-1.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous, active-low reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  controller can accept a command.
cmd_op  in  3  000 NOP, 001 LOAD, 010 SHR, 011 SHL, 100 ROR, 101 ROL, 110/111 reserved.
cmd_cnt  in  CNT_W  number of shift cycles (SHR/SHL/ROR/ROL).
cmd_fill  in  1  fill bit for SHR/SHL.
cmd_data  in  WIDTH  parallel word for LOAD.
q  in  WIDTH  current shift register Q.
sel  out  2  {S1,S0} to register: 00 hold, 01 shift right, 10 shift left, 11 load.
msb_in  out  1  serial input for right shift.
lsb_in  out  1  serial input for left shift.
par_out  out  WIDTH  parallel input I to register.
busy  out  1  high in LOAD/SHIFT/DONE.
done  out  1  one-cycle pulse on command completion.
err  out  1  one-cycle pulse with done for a reserved opcode.

Behaviour:
- Reset (rst=0 at clock edge): state IDLE; sel=00, done=0, err=0, busy=0, cmd_ready=1, latched command cleared. Reset mid-command abandons it at that edge. The register keeps its value; its own reset is driven separately.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE: cmd_ready=1, sel=00. When cmd_valid is high, latch op/cnt/fill/data. Next state:
  - LOAD for op LOAD.
  - SHIFT for shift/rotate ops with cnt≠0.
  - DONE for NOP, for cnt=0, and for reserved ops (err set).
- cmd_ready=0 in all other states. cmd_valid is ignored outside IDLE.
- LOAD: one cycle. sel=11, par_out=latched data; register loads at the end of the cycle. Then DONE.
- SHIFT: remaining-count register is initialised to cnt on accept and decremented each SHIFT cycle. Exit to DONE in the cycle the count equals 1, so exactly cnt shift cycles occur.
  - SHR: sel=01, msb_in=fill.
  - SHL: sel=10, lsb_in=fill.
  - ROR: sel=01, msb_in=q[0] (combinational from live q).
  - ROL: sel=10, lsb_in=q[WIDTH-1].
- DONE: sel=00, done=1 for one cycle, err=1 if reserved op. Then IDLE.
- Latency from accept edge:
  - LOAD: register updated after 2 edges; done in cycle 2.
  - Shift of N: done in cycle N+1.
  - NOP / cnt=0 / reserved: done in cycle 1.
  - Next accept possible the cycle after DONE.
- Unused outputs when not driving: msb_in=0, lsb_in=0, par_out=0.
- sel, msb_in, lsb_in and par_out are combinational from state, latched command and q; done, err and busy are decoded from state.
- Rotate counts greater than WIDTH are legal and wrap naturally.

Optional Feature:
USR_SEQ_CTRL_ABORT_EN:
- Enabled: adds input abort (1 bit) and output aborted (1 bit). abort=1 in LOAD or SHIFT forces sel=00 that same cycle and transitions to DONE; aborted pulses together with done. abort is ignored in IDLE and DONE.
- Disabled: the abort and aborted ports are absent, and every command runs to completion.

Decomposition:
- Package usr_seq_pkg holds: opcode localparams, mode encodings (MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11), state encoding.
- One sub-module, usr_shift_cnt: loadable CNT_W-bit down-counter with a last flag (count==1).

Test Plan:
- LOAD data=4'hA from IDLE → sel=11 in cycle 1; q=1010 and done=1 in cycle 2; cmd_ready=1 in cycle 3.
- q=1010, SHR cnt=2 fill=1 → sel=01 for exactly 2 cycles; q=1101 then 1110; done in cycle 3.
- q=1001, ROL cnt=1 → sel=10, lsb_in=1; q=0011. Also q=1001, ROR cnt=4 → q=1001 after 4 shifts.
- SHL cnt=0, and opcode 3'b111 → no sel activity; done in cycle 1; err=1 only for 3'b111.
- rst=0 during cycle 2 of SHR cnt=5 → next cycle IDLE, sel=00, no done pulse; q holds its partially shifted value.
- (ABORT_EN) abort in 2nd SHIFT cycle of ROR cnt=4 → sel=00 that cycle, done=aborted=1 next cycle, only 1 rotation applied.
